// File: rtl/fp_unpack_norm.sv
// Floating-point unpack/classify stage with valid/ready handshake.
// Optional subnormal normalisation is enabled by defining FP_UNPACK_SUBNORM_NORM_EN.
module fp_unpack_norm #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [EXP_W+1:0]        out_exp,
    output logic [FRAC_W:0]         out_mant,
    output logic [2:0]              out_class
);

    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] ONE_X  = XW'(1);

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_NAN  = 3'd4;

`ifdef FP_UNPACK_SUBNORM_NORM_EN
    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_SHIFT = 2'd1, ST_FULL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd2} state_t;
`endif

    state_t              state_r;
    state_t              state_nxt_s;
    state_t              route_s;
    logic                valid_r;
    logic                sign_r;
    logic [XW-1:0]       exp_r;
    logic [FRAC_W:0]     mant_r;
    logic [2:0]          class_r;
    logic                in_ready_s;
    logic                load_s;

    logic [EXP_W-1:0]    e_s;
    logic [FRAC_W-1:0]   f_s;
    logic [XW-1:0]       unp_exp_s;
    logic [FRAC_W:0]     unp_mant_s;
    logic [2:0]          unp_class_s;
    logic                unp_sub_s;

    assign e_s = in_data[EXP_W+FRAC_W-1:FRAC_W];
    assign f_s = in_data[FRAC_W-1:0];

    // Field decode and classification of the offered word
    always_comb begin
        unp_exp_s   = '0;
        unp_mant_s  = '0;
        unp_class_s = CLS_ZERO;
        unp_sub_s   = 1'b0;
        if (e_s == '0) begin
            if (f_s == '0) begin
                unp_class_s = CLS_ZERO;
            end else begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
                unp_exp_s   = ONE_X - BIAS_X;
                unp_mant_s  = {1'b0, f_s};
                unp_class_s = CLS_SUB;
                unp_sub_s   = 1'b1;
`else
                // Flush-to-zero keeps only the sign
                unp_class_s = CLS_ZERO;
`endif
            end
        end else if (&e_s) begin
            unp_exp_s   = BIAS_X + ONE_X;
            unp_mant_s  = {1'b0, f_s};
            unp_class_s = (f_s == '0) ? CLS_INF : CLS_NAN;
        end else begin
            unp_exp_s   = {2'b00, e_s} - BIAS_X;
            unp_mant_s  = {1'b1, f_s};
            unp_class_s = CLS_NORM;
        end
    end

    // Destination state for a freshly accepted word
    always_comb begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
        if (unp_sub_s) begin
            route_s = ST_SHIFT;
        end else begin
            route_s = ST_FULL;
        end
`else
        route_s = (unp_sub_s) ? ST_EMPTY : ST_FULL;
`endif
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt_s = state_r;
        in_ready_s  = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    load_s      = 1'b1;
                    state_nxt_s = route_s;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
`ifdef FP_UNPACK_SUBNORM_NORM_EN
            ST_SHIFT: begin
                // Bit below the hidden position becomes the hidden bit after this shift
                if (mant_r[FRAC_W-1]) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
`endif
            ST_FULL: begin
                in_ready_s = out_ready;
                if (out_ready && in_valid) begin
                    load_s      = 1'b1;
                    state_nxt_s = route_s;
                end else if (out_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State, valid flag and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            sign_r  <= 1'b0;
            exp_r   <= '0;
            mant_r  <= '0;
            class_r <= CLS_ZERO;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s == ST_FULL);
            if (load_s) begin
                sign_r  <= in_data[EXP_W+FRAC_W];
                exp_r   <= unp_exp_s;
                mant_r  <= unp_mant_s;
                class_r <= unp_class_s;
            end
`ifdef FP_UNPACK_SUBNORM_NORM_EN
            else if (state_r == ST_SHIFT) begin
                mant_r <= {mant_r[FRAC_W-1:0], 1'b0};
                exp_r  <= exp_r - ONE_X;
            end
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_r;
    assign out_sign  = sign_r;
    assign out_exp   = exp_r;
    assign out_mant  = mant_r;
    assign out_class = class_r;

endmodule

// File: tb/tb_fp_unpack_norm.sv
// Scoreboard bench for fp_unpack_norm at EXP_W=8, FRAC_W=23.
// Expected results follow FP_UNPACK_SUBNORM_NORM_EN when it is defined.
module tb_fp_unpack_norm;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_ready;
    logic        out_valid;
    logic        out_sign;
    logic [9:0]  out_exp;
    logic [23:0] out_mant;
    logic [2:0]  out_class;

    fp_unpack_norm #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant), .out_class(out_class)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [23:0] m;
        logic [2:0]  c;
    } res_t;

    res_t exp_q[$];
    res_t mon_x;
    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    function automatic res_t model(input logic [31:0] d);
        res_t        r;
        int          e;
        int          ex;
        logic [22:0] f;
        logic [23:0] m;
        e   = int'(d[30:23]);
        f   = d[22:0];
        r.s = d[31];
        ex  = 0;
        m   = 24'h0;
        if (e == 0 && f == 23'h0) begin
            r.e = 10'h0; r.m = 24'h0; r.c = 3'd0;
        end else if (e == 0) begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
            ex = -126;
            m  = {1'b0, f};
            while (!m[23]) begin
                m  = m << 1;
                ex = ex - 1;
            end
            r.e = 10'(ex); r.m = m; r.c = 3'd1;
`else
            r.e = 10'h0; r.m = 24'h0; r.c = 3'd0;
`endif
        end else if (e == 255) begin
            r.e = 10'd128; r.m = {1'b0, f}; r.c = (f == 23'h0) ? 3'd3 : 3'd4;
        end else begin
            r.e = 10'(e - 127); r.m = {1'b1, f}; r.c = 3'd2;
        end
        return r;
    endfunction

    // Scoreboard: pop on output handshake, push on input handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    mon_x = exp_q.pop_front();
                    check("sign",  64'(out_sign),  64'(mon_x.s));
                    check("exp",   64'(out_exp),   64'(mon_x.e));
                    check("mant",  64'(out_mant),  64'(mon_x.m));
                    check("class", 64'(out_class), 64'(mon_x.c));
                end
                out_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [37:0] snap;
    int          cyc;
    int          cnt0;
    logic [31:0] stream [4] = '{32'h40000000, 32'h40400000, 32'hC0800000, 32'h00000000};

    initial begin
        // reset state
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_outs",  64'({out_sign, out_exp, out_mant, out_class}), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // normal word, 1-cycle latency
        in_valid = 1'b1; in_data = 32'h3F800000;
        tick();
        in_valid = 1'b0;
        check("norm_latency", 64'(out_valid), 64'd1);
        tick();

        // smallest subnormal
        in_valid = 1'b1; in_data = 32'h00000001;
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (cyc == 1) in_valid = 1'b0;
        end while (!out_valid && cyc < 100);
`ifdef FP_UNPACK_SUBNORM_NORM_EN
        check("sub_latency", 64'(cyc), 64'd24);
        check("sub_exp", 64'(out_exp), 64'h36B);
        check("sub_mant", 64'(out_mant), 64'h800000);
`else
        check("sub_latency", 64'(cyc), 64'd1);
        check("sub_flush", 64'(out_class), 64'd0);
`endif
        tick();

        // INF then NaN back to back
        in_valid = 1'b1; in_data = 32'hFF800000;
        tick();
        in_data = 32'h7FC00001;
        tick();
        in_valid = 1'b0;
        check("nan_mant", 64'(out_mant), 64'h400001);
        tick();

        // 4-word stream at full throughput
        cnt0 = out_cnt;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = stream[i];
            check("stream_ready", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("stream_count", 64'(out_cnt), 64'(cnt0 + 4));
        tick();

        // backpressure: hold 5 cycles in FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h41200000;
        tick();
        in_data = 32'hC1A00000;
        snap = {out_sign, out_exp, out_mant, out_class};
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_hold", 64'({out_sign, out_exp, out_mant, out_class}), 64'(snap));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_pending_mant", 64'(out_mant), 64'h A00000);
        check("bp_pending_sign", 64'(out_sign), 64'd1);
        tick();

        // reset in the middle of a shift
        in_valid = 1'b1; in_data = 32'h00000001;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_outs", 64'({out_sign, out_exp, out_mant, out_class}), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        cnt0 = out_cnt;
        repeat (40) tick();
        check("no_stale_out", 64'(out_cnt), 64'(cnt0));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_unpack_norm.md
# fp_unpack_norm

Parametrised floating-point unpack stage with a valid/ready stream interface. Each accepted packed word is split into sign, unbiased exponent and an explicit-hidden-bit mantissa of width FRAC_W+1, and classified. Subnormals are optionally normalised by an iterative one-bit-per-cycle shifter. It sits at the input of the arithmetic datapath, ahead of the align/add stages.

## Interface
- EXP_W, 8, exponent field width; legal range ≥2.
- FRAC_W, 23, fraction field width; legal range ≥1 and ≤2^EXP_W. No zero-width slices are generated at FRAC_W=1.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  stage accepts in_data this cycle.
- in_data  input  EXP_W+FRAC_W+1  packed word as {sign, exp field, frac field}.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  sign bit.
- out_exp  output  EXP_W+2  two's-complement unbiased exponent.
- out_mant  output  FRAC_W+1  {hidden, frac}.
- out_class  output  3  0=ZERO, 1=SUBNORMAL, 2=NORMAL, 3=INF, 4=NAN.

## Operation
- BIAS = 2^(EXP_W-1)-1. The exponent field is e and the fraction field is f.
- Classification and results:
  - e=0, f=0: ZERO, out_exp=0, out_mant=0.
  - e=0, f≠0: SUBNORMAL, out_exp=1-BIAS, out_mant={1'b0,f} before normalisation.
  - 0<e<all-ones: NORMAL, out_exp=e-BIAS, out_mant={1'b1,f}.
  - e=all-ones, f=0: INF, out_exp=BIAS+1, out_mant=0.
  - e=all-ones, f≠0: NAN, out_exp=BIAS+1, out_mant={1'b0,f}.
- out_sign always equals the input sign bit, including for ZERO and NAN.
- FSM states are EMPTY, SHIFT and FULL.
- EMPTY:
  - in_ready=1.
  - A handshake (in_valid && in_ready) latches the results.
  - The next state is SHIFT if the input is SUBNORMAL and normalisation is compiled in. Otherwise it is FULL.
- SHIFT:
  - in_ready=0 and out_valid=0.
  - Each cycle does out_mant<<=1 and out_exp-=1.
  - When out_mant[FRAC_W]=1 after the shift, the next state is FULL.
  - Shift count k = number of leading zeros of f within FRAC_W bits, plus 1. So 1≤k≤FRAC_W.
- FULL:
  - out_valid=1.
  - in_ready=out_ready.
  - On out_ready with no new handshake, the next state is EMPTY.
  - On out_ready with a simultaneous handshake, the new word is latched and routed as from EMPTY. This gives back-to-back throughput.
- While out_valid && !out_ready, all out_* signals are held bit-stable.
- Arithmetic: out_exp is computed at EXP_W+2 bits, sign-extended. The minimum value is 1-BIAS-FRAC_W, which is representable for all legal parameters. No wrap occurs.

## Timing
- Reset (async assert, sync-released state) gives: state EMPTY, out_valid=0, out_sign=0, out_exp=0, out_mant=0, out_class=0, in_ready=1.
- Latency for non-subnormal words: out_valid rises on the edge that accepts the word, i.e. 1 cycle.
- Latency for subnormal words with normalisation: 1+k cycles.
- Throughput: 1 word/cycle for non-subnormal words while out_ready=1.
- in_ready is combinational from state and out_ready only. It never depends on in_valid.
- Reset asserted mid-SHIFT or in FULL immediately drops out_valid and discards the word. After release, no result is produced for that word.

## Configuration
- FP_UNPACK_SUBNORM_NORM_EN defined:
  - The SHIFT state and shifter are built.
  - Subnormals leave with class SUBNORMAL, out_mant[FRAC_W]=1, and the exponent adjusted.
- FP_UNPACK_SUBNORM_NORM_EN undefined:
  - SHIFT is absent.
  - Subnormals are flushed to zero: class ZERO, out_exp=0, out_mant=0, sign preserved.
  - Latency is 1 cycle for all inputs.

## Test plan
All scenarios use EXP_W=8, FRAC_W=23.
- in_data=0x3F800000, out_ready=1 -> one cycle later: sign 0, exp 0, mant 0x800000, class NORMAL.
- in_data=0x00000001, macro defined -> out_valid after 24 cycles with exp -149 (0x36B as 10-bit), mant 0x800000, class SUBNORMAL. Macro undefined -> after 1 cycle: class ZERO, exp 0, mant 0.
- in_data=0xFF800000 -> sign 1, exp 128, mant 0, class INF. in_data=0x7FC00001 -> class NAN, mant 0x400001.
- Stream 0x40000000, 0x40400000, 0xC0800000, 0x00000000 with in_valid=1 and out_ready=1 -> four results on consecutive cycles (exps 1, 1, 2, 0), with in_ready constantly 1.
- Hold out_ready=0 for 5 cycles in FULL with in_valid=1 -> in_ready=0, outputs unchanged. Raising out_ready -> the pending input is accepted that edge.
- Assert rst_n=0 during cycle 10 of SHIFT for 0x00000001 -> out_valid=0 and outputs zero immediately, in_ready=1 after release, no stale result emitted.
